multicycle_sequencer: RTL and testbench

//  Multi-cycle sequencer for the single-port CPU datapath. It steps each instruction through

---
 rtl/multicycle_sequencer_if.sv | 41 ++++
 rtl/multicycle_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_multicycle_sequencer.sv | 438 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_sequencer_if.sv
// Handshake bundle between the multicycle sequencer and the CPU datapath.
// Carries the start request, decoder flags, ALU zero flag and memory ack
// towards the sequencer, and the PC/IR/memory/register strobes plus
// status/debug outputs back to the datapath.
//   master : sequencer side (consumes decoder/memory inputs, drives strobes)
//   slave  : datapath / memory side (the mirror image)
interface multicycle_sequencer_if;
  logic       start;
  logic       dec_mem_read;
  logic       dec_mem_write;
  logic       dec_branch;
  logic       dec_jump;
  logic       dec_halt;
  logic       dec_reg_write;
  logic       zero_flag;
  logic       mem_ack;
  logic       ir_load;
  logic       pc_inc;
  logic       pc_load;
  logic       mem_req;
  logic       mem_we;
  logic       mem_addr_sel;
  logic       reg_we;
  logic       halted;
  logic       fault;
  logic [2:0] state;

  modport master (
    input  start, dec_mem_read, dec_mem_write, dec_branch, dec_jump,
           dec_halt, dec_reg_write, zero_flag, mem_ack,
    output ir_load, pc_inc, pc_load, mem_req, mem_we, mem_addr_sel,
           reg_we, halted, fault, state
  );

  modport slave (
    output start, dec_mem_read, dec_mem_write, dec_branch, dec_jump,
           dec_halt, dec_reg_write, zero_flag, mem_ack,
    input  ir_load, pc_inc, pc_load, mem_req, mem_we, mem_addr_sel,
           reg_we, halted, fault, state
  );
endinterface

// File: rtl/multicycle_sequencer.sv
// Multi-cycle control sequencer for the single-port CPU datapath.
// Steps each instruction through FETCH, DECODE, EXEC and optional MEM/WB,
// arbitrating the single memory port between instruction fetch and data
// access, with a memory-wait timeout that parks the machine in FAULT.
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-high reset
//   bus          multicycle_sequencer_if.master (decoder flags, zero flag,
//                memory ack in; PC/IR/memory/register strobes, halted,
//                fault and debug state out)
//   instr_count  retired-instruction counter, saturating (PERF_CNT_EN only)
// Parameters:
//   TIMEOUT_W    memory-wait counter width; wait limit = 2**TIMEOUT_W-1
//   CNT_W        retired-instruction counter width
// Build option: define PERF_CNT_EN to add the instr_count port.
module multicycle_sequencer #(
  parameter int unsigned TIMEOUT_W = 4,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  multicycle_sequencer_if.master bus
`ifdef PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]       instr_count
`endif
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6,
    S_FAULT  = 3'd7
  } state_e;

  // The fault is taken on the request cycle whose increment would make the
  // counter reach the limit, so an ack in that same cycle still wins.
  localparam int unsigned          WAIT_LAST_I = (1 << TIMEOUT_W) - 2;
  localparam logic [TIMEOUT_W-1:0] WAIT_LAST   = WAIT_LAST_I[TIMEOUT_W-1:0];

  state_e               state_q, state_d;
  logic [TIMEOUT_W-1:0] wait_q, wait_d;
  logic                 rd_q, rd_d;
  logic                 wr_q, wr_d;
  logic                 br_q, br_d;
  logic                 jp_q, jp_d;
  logic                 rw_q, rw_d;

  logic ir_load, pc_inc, pc_load, mem_req, mem_we, mem_addr_sel, reg_we;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      wait_q  <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      br_q    <= 1'b0;
      jp_q    <= 1'b0;
      rw_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      br_q    <= br_d;
      jp_q    <= jp_d;
      rw_q    <= rw_d;
    end
  end

  // The wait counter only survives while a request is still pending, so it
  // is zero on every entry to FETCH or MEM.
  always_comb begin
    state_d      = state_q;
    wait_d       = '0;
    rd_d         = rd_q;
    wr_d         = wr_q;
    br_d         = br_q;
    jp_d         = jp_q;
    rw_d         = rw_q;
    ir_load      = 1'b0;
    pc_inc       = 1'b0;
    pc_load      = 1'b0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    reg_we       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) state_d = S_FETCH;
      end
      S_FETCH: begin
        mem_req = 1'b1;
        if (bus.mem_ack) begin
          ir_load = 1'b1;
          pc_inc  = 1'b1;
          state_d = S_DECODE;
        end else if (wait_q == WAIT_LAST) begin
          state_d = S_FAULT;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_DECODE: begin
        rd_d    = bus.dec_mem_read;
        wr_d    = bus.dec_mem_write;
        br_d    = bus.dec_branch;
        jp_d    = bus.dec_jump;
        rw_d    = bus.dec_reg_write;
        state_d = bus.dec_halt ? S_HALT : S_EXEC;
      end
      S_EXEC: begin
        if (jp_q) begin
          pc_load = 1'b1;
          state_d = S_FETCH;
        end else if (br_q) begin
          pc_load = bus.zero_flag;
          state_d = S_FETCH;
        end else if (rd_q || wr_q) begin
          state_d = S_MEM;
        end else if (rw_q) begin
          state_d = S_WB;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_MEM: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        // A read+write combination behaves as a plain read.
        mem_we       = wr_q & ~rd_q;
        if (bus.mem_ack) begin
          state_d = rd_q ? S_WB : S_FETCH;
        end else if (wait_q == WAIT_LAST) begin
          state_d = S_FAULT;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_WB: begin
        reg_we  = 1'b1;
        state_d = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.ir_load      = ir_load;
  assign bus.pc_inc       = pc_inc;
  assign bus.pc_load      = pc_load;
  assign bus.mem_req      = mem_req;
  assign bus.mem_we       = mem_we;
  assign bus.mem_addr_sel = mem_addr_sel;
  assign bus.reg_we       = reg_we;
  assign bus.halted       = (state_q == S_HALT);
  assign bus.fault        = (state_q == S_FAULT);
  assign bus.state        = state_q;

`ifdef PERF_CNT_EN
  logic             retire;
  logic [CNT_W-1:0] cnt_q;

  assign retire = ((state_d == S_FETCH) &&
                   (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB)) ||
                  ((state_d == S_HALT) && (state_q != S_HALT));

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (retire && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign instr_count = cnt_q;
`endif

endmodule

// File: tb/tb_multicycle_sequencer.sv
module tb_multicycle_sequencer;

  typedef struct packed {
    logic rd, wr, br, jp, ht, rw;
  } instr_t;

  typedef struct packed {
    logic [7:0] cycles;
    logic [3:0] n_fetch;
    logic [3:0] n_ir;
    logic [3:0] n_inc;
    logic [3:0] n_pcl;
    logic [7:0] pcl_at;
    logic [3:0] n_rwe;
    logic [7:0] rwe_at;
    logic [3:0] n_data;
    logic [3:0] n_we;
    logic [2:0] end_st;
  } meas_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, start, d_rd, d_wr, d_br, d_jp, d_ht, d_rw, zero, ack;
  logic sel;
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  multicycle_sequencer_if bus_a ();
  multicycle_sequencer_if bus_b ();

  assign bus_a.start = start;         assign bus_b.start = start;
  assign bus_a.dec_mem_read = d_rd;   assign bus_b.dec_mem_read = d_rd;
  assign bus_a.dec_mem_write = d_wr;  assign bus_b.dec_mem_write = d_wr;
  assign bus_a.dec_branch = d_br;     assign bus_b.dec_branch = d_br;
  assign bus_a.dec_jump = d_jp;       assign bus_b.dec_jump = d_jp;
  assign bus_a.dec_halt = d_ht;       assign bus_b.dec_halt = d_ht;
  assign bus_a.dec_reg_write = d_rw;  assign bus_b.dec_reg_write = d_rw;
  assign bus_a.zero_flag = zero;      assign bus_b.zero_flag = zero;
  assign bus_a.mem_ack = ack;         assign bus_b.mem_ack = ack;

`ifdef PERF_CNT_EN
  logic [15:0] cnt_a;
  logic [1:0]  cnt_b;
`endif

  multicycle_sequencer #(.TIMEOUT_W(4), .CNT_W(16)) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a)
`ifdef PERF_CNT_EN
    , .instr_count(cnt_a)
`endif
  );

  multicycle_sequencer #(.TIMEOUT_W(2), .CNT_W(2)) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b)
`ifdef PERF_CNT_EN
    , .instr_count(cnt_b)
`endif
  );

  logic [2:0] o_state;
  logic o_ir, o_inc, o_pcl, o_req, o_we, o_sel, o_rwe, o_halt, o_fault;
  always_comb begin
    o_state = sel ? bus_b.state        : bus_a.state;
    o_ir    = sel ? bus_b.ir_load      : bus_a.ir_load;
    o_inc   = sel ? bus_b.pc_inc       : bus_a.pc_inc;
    o_pcl   = sel ? bus_b.pc_load      : bus_a.pc_load;
    o_req   = sel ? bus_b.mem_req      : bus_a.mem_req;
    o_we    = sel ? bus_b.mem_we       : bus_a.mem_we;
    o_sel   = sel ? bus_b.mem_addr_sel : bus_a.mem_addr_sel;
    o_rwe   = sel ? bus_b.reg_we       : bus_a.reg_we;
    o_halt  = sel ? bus_b.halted       : bus_a.halted;
    o_fault = sel ? bus_b.fault        : bus_a.fault;
  end

  // Instruction-level reference: cycle counts and strobe totals derived from
  // the instruction class and the memory wait states.
  function automatic meas_t model(input instr_t in, input logic z, input int fw, input int mw);
    meas_t m;
    int fc, dc, cyc;
    m = '0;
    fc = fw + 1;
    m.n_fetch = 4'(fc);
    m.n_ir = 4'd1;
    m.n_inc = 4'd1;
    if (in.ht) begin
      m.cycles = 8'(fc + 1);
      m.end_st = 3'd6;
      return m;
    end
    m.end_st = 3'd1;
    if (in.jp) begin
      cyc = fc + 2;
      m.n_pcl = 4'd1;
      m.pcl_at = 8'(cyc);
    end else if (in.br) begin
      cyc = fc + 2;
      if (z) begin
        m.n_pcl = 4'd1;
        m.pcl_at = 8'(cyc);
      end
    end else if (in.rd || in.wr) begin
      dc = mw + 1;
      m.n_data = 4'(dc);
      if (!in.rd) m.n_we = 4'(dc);
      cyc = fc + 2 + dc + (in.rd ? 1 : 0);
      if (in.rd) begin
        m.n_rwe = 4'd1;
        m.rwe_at = 8'(cyc);
      end
    end else if (in.rw) begin
      cyc = fc + 3;
      m.n_rwe = 4'd1;
      m.rwe_at = 8'(cyc);
    end else begin
      cyc = fc + 2;
    end
    m.cycles = 8'(cyc);
    return m;
  endfunction

  function automatic string fmt(input meas_t m);
    return $sformatf("cyc=%0d fetch=%0d ir=%0d inc=%0d pcl=%0d@%0d rwe=%0d@%0d data=%0d we=%0d end=%0d",
                     m.cycles, m.n_fetch, m.n_ir, m.n_inc, m.n_pcl, m.pcl_at,
                     m.n_rwe, m.rwe_at, m.n_data, m.n_we, m.end_st);
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; start = 1'b0; ack = 1'b0;
    {d_rd, d_wr, d_br, d_jp, d_ht, d_rw} = '0;
    zero = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Called at a negedge with the selected DUT in IDLE; returns at a negedge in FETCH.
  task automatic enter_fetch();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Drives one instruction starting at a negedge in FETCH, acting as memory
  // and decoder; returns at the negedge where the next FETCH/HALT is seen.
  task automatic run_instr(input instr_t in, input logic z, input int fw, input int mw,
                           output meas_t m);
    int fcnt, mcnt;
    bit left;
    logic [2:0] st;
    fcnt = 0; mcnt = 0; left = 0;
    m = '0;
    for (int it = 0; it < 60; it++) begin
      if (it > 0) @(negedge clk);
      st = o_state;
      if (it > 0 && ((st == 3'd1 && left) || st == 3'd6 || st == 3'd7 || st == 3'd0)) begin
        m.end_st = st;
        break;
      end
      if (st != 3'd1) left = 1;
      start = 1'($urandom);
      if (st == 3'd2) {d_rd, d_wr, d_br, d_jp, d_ht, d_rw} = in;
      else {d_rd, d_wr, d_br, d_jp, d_ht, d_rw} = 6'($urandom);
      zero = (st == 3'd3) ? z : 1'($urandom);
      if (st == 3'd1) begin
        ack = (fcnt == fw);
        fcnt++;
      end else if (st == 3'd4) begin
        ack = (mcnt == mw);
        mcnt++;
      end else begin
        ack = 1'($urandom);
      end
      #1;
      m.cycles = m.cycles + 8'd1;
      if (o_req && !o_sel) m.n_fetch = m.n_fetch + 4'd1;
      if (o_req && o_sel)  m.n_data  = m.n_data + 4'd1;
      if (o_req && o_we)   m.n_we    = m.n_we + 4'd1;
      if (o_ir)  m.n_ir  = m.n_ir + 4'd1;
      if (o_inc) m.n_inc = m.n_inc + 4'd1;
      if (o_pcl) begin
        m.n_pcl = m.n_pcl + 4'd1;
        m.pcl_at = m.cycles;
      end
      if (o_rwe) begin
        m.n_rwe = m.n_rwe + 4'd1;
        m.rwe_at = m.cycles;
      end
    end
    start = 1'b0;
    ack = 1'b0;
  endtask

  task automatic test_reset();
    for (int d = 0; d < 2; d++) begin
      sel = 1'(d);
      do_reset();
      #1;
      n_checks++;
      if (o_state !== 3'd0) $display("FAIL reset_state dut%0d: got %0d want 0", d, o_state);
      else n_pass++;
      n_checks++;
      if ({o_ir, o_inc, o_pcl, o_req, o_we, o_sel, o_rwe, o_halt, o_fault} !== 9'b0)
        $display("FAIL reset_outputs dut%0d: got %b want 000000000", d,
                 {o_ir, o_inc, o_pcl, o_req, o_we, o_sel, o_rwe, o_halt, o_fault});
      else n_pass++;
    end
`ifdef PERF_CNT_EN
    n_checks++;
    if (cnt_a !== 16'd0 || cnt_b !== 2'd0)
      $display("FAIL reset_count: got %0d/%0d want 0/0", cnt_a, cnt_b);
    else n_pass++;
`endif
  endtask

  task automatic test_reset_mid_fetch();
    sel = 1'b0;
    do_reset();
    enter_fetch();
    #1;
    n_checks++;
    if (o_req !== 1'b1) $display("FAIL midfetch_req: got %b want 1", o_req);
    else n_pass++;
    reset = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (o_req !== 1'b0 || o_state !== 3'd0)
      $display("FAIL midfetch_reset_edge: got req=%b state=%0d want req=0 state=0", o_req, o_state);
    else n_pass++;
    @(negedge clk);
    reset = 1'b0;
    ack = 1'b1;
    #1;
    n_checks++;
    if (o_ir !== 1'b0 || o_inc !== 1'b0)
      $display("FAIL midfetch_late_ack: got ir=%b inc=%b want 0 0", o_ir, o_inc);
    else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if (o_state !== 3'd0) $display("FAIL midfetch_stay_idle: got %0d want 0", o_state);
    else n_pass++;
    ack = 1'b0;
  endtask

  task automatic test_alu();
    meas_t m, e;
    instr_t in;
    sel = 1'b0;
    do_reset();
    enter_fetch();
    in = '{rd:0, wr:0, br:0, jp:0, ht:0, rw:1};
    run_instr(in, 1'b0, 0, 0, m);
    e = model(in, 1'b0, 0, 0);
    n_checks++;
    if (m !== e) $display("FAIL alu_op: got %s want %s", fmt(m), fmt(e));
    else n_pass++;
    n_checks++;
    if (m.cycles !== 8'd4 || m.rwe_at !== 8'd4 || m.end_st !== 3'd1)
      $display("FAIL alu_latency: got cyc=%0d rwe_at=%0d end=%0d want 4 4 1", m.cycles, m.rwe_at, m.end_st);
    else n_pass++;
  endtask

  task automatic test_load_store();
    meas_t m, e;
    instr_t ld, stv, both;
    ld   = '{rd:1, wr:0, br:0, jp:0, ht:0, rw:1};
    stv  = '{rd:0, wr:1, br:0, jp:0, ht:0, rw:0};
    both = '{rd:1, wr:1, br:0, jp:0, ht:0, rw:1};
    run_instr(ld, 1'b0, 0, 3, m);
    e = model(ld, 1'b0, 0, 3);
    n_checks++;
    if (m.n_data !== 4'd4 || m.n_rwe !== 4'd1 || m !== e)
      $display("FAIL load_wait3: got %s want %s", fmt(m), fmt(e));
    else n_pass++;
    run_instr(stv, 1'b0, 1, 3, m);
    e = model(stv, 1'b0, 1, 3);
    n_checks++;
    if (m.n_we !== 4'd4 || m.n_rwe !== 4'd0 || m !== e)
      $display("FAIL store_wait3: got %s want %s", fmt(m), fmt(e));
    else n_pass++;
    run_instr(both, 1'b0, 0, 1, m);
    e = model(both, 1'b0, 0, 1);
    n_checks++;
    if (m !== e) $display("FAIL read_write_as_read: got %s want %s", fmt(m), fmt(e));
    else n_pass++;
  endtask

  task automatic test_branch();
    meas_t m, e;
    instr_t br;
    br = '{rd:0, wr:0, br:1, jp:0, ht:0, rw:0};
    for (int z = 1; z >= 0; z--) begin
      run_instr(br, 1'(z), 0, 0, m);
      e = model(br, 1'(z), 0, 0);
      n_checks++;
      if (m !== e) $display("FAIL branch_z%0d: got %s want %s", z, fmt(m), fmt(e));
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    meas_t m, e;
    instr_t in;
    logic z;
    int fw, mw;
    int retired;
    sel = 1'b0;
    do_reset();
    enter_fetch();
    retired = 0;
    for (int i = 0; i < 40; i++) begin
      in = 6'($urandom);
      in.ht = 1'b0;
      z = 1'($urandom);
      fw = int'($urandom_range(0, 5));
      mw = int'($urandom_range(0, 5));
      run_instr(in, z, fw, mw, m);
      e = model(in, z, fw, mw);
      retired++;
      n_checks++;
      if (m !== e) $display("FAIL random_instr_%0d (flags=%b z=%b fw=%0d mw=%0d): got %s want %s",
                            i, in, z, fw, mw, fmt(m), fmt(e));
      else n_pass++;
`ifdef PERF_CNT_EN
      n_checks++;
      if (cnt_a !== 16'(retired)) $display("FAIL random_count_%0d: got %0d want %0d", i, cnt_a, retired);
      else n_pass++;
`endif
    end
  endtask

  task automatic test_halt();
    meas_t m, e;
    instr_t alu, ht;
    sel = 1'b0;
    alu = '{rd:0, wr:0, br:0, jp:0, ht:0, rw:1};
    ht  = '{rd:0, wr:0, br:0, jp:0, ht:1, rw:0};
    do_reset();
    enter_fetch();
    run_instr(alu, 1'b0, 0, 0, m);
    run_instr(alu, 1'b0, 2, 0, m);
    run_instr(ht, 1'b0, 1, 0, m);
    e = model(ht, 1'b0, 1, 0);
    n_checks++;
    if (m !== e) $display("FAIL halt_instr: got %s want %s", fmt(m), fmt(e));
    else n_pass++;
    start = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    n_checks++;
    if (o_state !== 3'd6 || o_halt !== 1'b1 || o_req !== 1'b0)
      $display("FAIL halt_sticky: got state=%0d halted=%b req=%b want 6 1 0", o_state, o_halt, o_req);
    else n_pass++;
    start = 1'b0;
`ifdef PERF_CNT_EN
    n_checks++;
    if (cnt_a !== 16'd3) $display("FAIL halt_count: got %0d want 3", cnt_a);
    else n_pass++;
`endif
  endtask

  task automatic test_timeout();
    meas_t m, e;
    instr_t alu;
    int req_cnt;
    sel = 1'b1;
    do_reset();
    enter_fetch();
    req_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      ack = 1'b0;
      #1;
      if (o_state == 3'd7) break;
      if (o_req) req_cnt++;
      @(negedge clk);
    end
    n_checks++;
    if (req_cnt != 3) $display("FAIL timeout_wait_cycles: got %0d want 3", req_cnt);
    else n_pass++;
    n_checks++;
    if (o_fault !== 1'b1 || o_req !== 1'b0)
      $display("FAIL timeout_fault: got fault=%b req=%b want 1 0", o_fault, o_req);
    else n_pass++;
    start = 1'b1;
    ack = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    n_checks++;
    if (o_state !== 3'd7 || o_fault !== 1'b1)
      $display("FAIL timeout_sticky: got state=%0d fault=%b want 7 1", o_state, o_fault);
    else n_pass++;
    start = 1'b0;
    ack = 1'b0;
    do_reset();
    enter_fetch();
    alu = '{rd:0, wr:0, br:0, jp:0, ht:0, rw:1};
    run_instr(alu, 1'b0, 2, 0, m);
    e = model(alu, 1'b0, 2, 0);
    n_checks++;
    if (m !== e || o_fault !== 1'b0)
      $display("FAIL timeout_ack_at_limit: got %s fault=%b want %s fault=0", fmt(m), o_fault, fmt(e));
    else n_pass++;
  endtask

`ifdef PERF_CNT_EN
  task automatic test_saturation();
    meas_t m;
    instr_t alu;
    sel = 1'b1;
    alu = '{rd:0, wr:0, br:0, jp:0, ht:0, rw:1};
    do_reset();
    enter_fetch();
    for (int i = 0; i < 5; i++) run_instr(alu, 1'b0, 0, 0, m);
    n_checks++;
    if (cnt_b !== 2'd3) $display("FAIL count_saturate: got %0d want 3", cnt_b);
    else n_pass++;
  endtask
`endif

  initial begin
    reset = 1'b1; start = 1'b0; ack = 1'b0; zero = 1'b0; sel = 1'b0;
    {d_rd, d_wr, d_br, d_jp, d_ht, d_rw} = '0;
    test_reset();
    test_reset_mid_fetch();
    test_alu();
    test_load_store();
    test_branch();
    test_back_to_back();
    test_halt();
    test_timeout();
`ifdef PERF_CNT_EN
    test_saturation();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
